spi_input_frontend: RTL and testbench



---
 rtl/spi_pkg.sv | 12 +
 rtl/spi_input_frontend_if.sv | 27 ++
 rtl/spi_input_frontend_conditioner.sv | 73 +++++++
 rtl/spi_input_frontend.sv | 50 +++++
 tb/tb_spi_input_frontend.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared constants for the SPI input frontend.
//   WAIT_TIME_DEFAULT : debounce length in clk cycles
//   *_RST             : level each conditioned channel takes in reset
package spi_pkg;

    localparam int   WAIT_TIME_DEFAULT = 3;

    localparam logic SCLK_RST = 1'b0;
    localparam logic CS_RST   = 1'b1;  // chip select idles deasserted
    localparam logic MOSI_RST = 1'b0;

endpackage

// File: rtl/spi_input_frontend_if.sv
// Conditioned SPI levels and edge pulses handed to the control FSM and
// shift register.
//   master : driven by spi_input_frontend
//   slave  : consumed by the FSM / shift register
interface spi_input_frontend_if;

    logic sclk_cond;
    logic sclk_posedge;
    logic sclk_negedge;
    logic cs_cond;
    logic cs_negedge;
    logic cs_posedge;
    logic mosi_cond;

    modport master (
        output sclk_cond, sclk_posedge, sclk_negedge,
        output cs_cond, cs_negedge, cs_posedge,
        output mosi_cond
    );

    modport slave (
        input sclk_cond, sclk_posedge, sclk_negedge,
        input cs_cond, cs_negedge, cs_posedge,
        input mosi_cond
    );

endinterface

// File: rtl/spi_input_frontend_conditioner.sv
// One input channel: 2-flop synchronizer, debounce filter, edge pulses.
//   clk, reset    : system clock, synchronous active-high reset
//   noisysignal   : raw asynchronous pin
//   conditioned   : debounced level (registered)
//   positiveedge  : one-cycle pulse when conditioned rises
//   negativeedge  : one-cycle pulse when conditioned falls
module input_conditioner
    import spi_pkg::*;
#(
    parameter int   WAIT_TIME = WAIT_TIME_DEFAULT,
    parameter logic RST_VAL   = 1'b0,
    localparam int  CNT_W     = $clog2(WAIT_TIME + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic noisysignal,
    output logic conditioned,
    output logic positiveedge,
    output logic negativeedge
);

    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(WAIT_TIME - 1);

    logic             sync0_q, sync0_d;
    logic             sync1_q, sync1_d;
    logic             cond_q, cond_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pos_q, pos_d;
    logic             neg_q, neg_d;

    always_comb begin
        sync0_d = noisysignal;
        sync1_d = sync0_q;
        cond_d  = cond_q;
        cnt_d   = '0;
        pos_d   = 1'b0;
        neg_d   = 1'b0;
        // Any return to the old level drops the count, so bounce restarts it.
        if (sync1_q != cond_q) begin
            if (cnt_q == CNT_TC) begin
                cond_d = sync1_q;
                pos_d  = sync1_q;
                neg_d  = ~sync1_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // Sync flops take the reset level too, so no edge fires on release.
            sync0_q <= RST_VAL;
            sync1_q <= RST_VAL;
            cond_q  <= RST_VAL;
            cnt_q   <= '0;
            pos_q   <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            sync0_q <= sync0_d;
            sync1_q <= sync1_d;
            cond_q  <= cond_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            neg_q   <= neg_d;
        end
    end

    assign conditioned  = cond_q;
    assign positiveedge = pos_q;
    assign negativeedge = neg_q;

endmodule

// File: rtl/spi_input_frontend.sv
// Conditions raw SCLK, CS and MOSI pins into clean clk-domain levels and
// edge pulses.
//   clk, reset                  : system clock, synchronous active-high reset
//   sclk_pin, cs_pin, mosi_pin  : raw asynchronous pins (cs active low)
//   fe_o                        : conditioned levels and edge pulses
module spi_input_frontend
    import spi_pkg::*;
#(
    parameter int WAIT_TIME = WAIT_TIME_DEFAULT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        sclk_pin,
    input  logic                        cs_pin,
    input  logic                        mosi_pin,
    spi_input_frontend_if.master        fe_o
);

    input_conditioner #(.WAIT_TIME(WAIT_TIME), .RST_VAL(SCLK_RST)) u_sclk (
        .clk          (clk),
        .reset        (reset),
        .noisysignal  (sclk_pin),
        .conditioned  (fe_o.sclk_cond),
        .positiveedge (fe_o.sclk_posedge),
        .negativeedge (fe_o.sclk_negedge)
    );

    input_conditioner #(.WAIT_TIME(WAIT_TIME), .RST_VAL(CS_RST)) u_cs (
        .clk          (clk),
        .reset        (reset),
        .noisysignal  (cs_pin),
        .conditioned  (fe_o.cs_cond),
        .positiveedge (fe_o.cs_posedge),
        .negativeedge (fe_o.cs_negedge)
    );

    // MOSI is consumed as a level only; its pulses are left unconnected.
    logic mosi_pos_unused;
    logic mosi_neg_unused;

    input_conditioner #(.WAIT_TIME(WAIT_TIME), .RST_VAL(MOSI_RST)) u_mosi (
        .clk          (clk),
        .reset        (reset),
        .noisysignal  (mosi_pin),
        .conditioned  (fe_o.mosi_cond),
        .positiveedge (mosi_pos_unused),
        .negativeedge (mosi_neg_unused)
    );

endmodule

// File: tb/tb_spi_input_frontend.sv
// Directed bench: a table of per-cycle {reset, pins, expected outputs} for the
// WAIT_TIME=3 build, plus a hand-written sequence on a WAIT_TIME=1 build.
// Expected output bundle order:
//   {sclk_cond, sclk_posedge, sclk_negedge, cs_cond, cs_negedge, cs_posedge, mosi_cond}
module tb_spi_input_frontend;

    logic clk = 1'b0;
    logic reset;
    logic sclk_pin, cs_pin, mosi_pin;
    logic sclk1_pin, cs1_pin, mosi1_pin;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spi_input_frontend_if fe0 ();
    spi_input_frontend_if fe1 ();

    spi_input_frontend #(.WAIT_TIME(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .sclk_pin (sclk_pin),
        .cs_pin   (cs_pin),
        .mosi_pin (mosi_pin),
        .fe_o     (fe0)
    );

    spi_input_frontend #(.WAIT_TIME(1)) dut_w1 (
        .clk      (clk),
        .reset    (reset),
        .sclk_pin (sclk1_pin),
        .cs_pin   (cs1_pin),
        .mosi_pin (mosi1_pin),
        .fe_o     (fe1)
    );

    wire [6:0] obs0 = {fe0.sclk_cond, fe0.sclk_posedge, fe0.sclk_negedge,
                       fe0.cs_cond, fe0.cs_negedge, fe0.cs_posedge, fe0.mosi_cond};
    wire [6:0] obs1 = {fe1.sclk_cond, fe1.sclk_posedge, fe1.sclk_negedge,
                       fe1.cs_cond, fe1.cs_negedge, fe1.cs_posedge, fe1.mosi_cond};

    typedef struct {
        string      name;
        logic       rst;
        logic       sclk;
        logic       cs;
        logic       mosi;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[$];

    localparam logic [6:0] IDLE = 7'b0001000;

    function automatic void add(string name, logic rst, logic sclk, logic cs,
                                logic mosi, logic [6:0] exp);
        vec_t v;
        v.name = name; v.rst = rst; v.sclk = sclk; v.cs = cs; v.mosi = mosi; v.exp = exp;
        vecs.push_back(v);
    endfunction

    function automatic void add_reset(string name);
        add(name, 1'b1, 1'b0, 1'b1, 1'b0, IDLE);
        add(name, 1'b1, 1'b0, 1'b1, 1'b0, IDLE);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [6:0] act, logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    initial begin
        // 1: reset with pins opposite to reset levels, then release
        add("rst_hold", 1, 1, 0, 1, IDLE);
        add("rst_hold", 1, 1, 0, 1, IDLE);
        for (int i = 0; i < 4; i++) add("rst_release", 0, 1, 0, 1, IDLE);
        add("rst_release_edge", 0, 1, 0, 1, 7'b1100101);
        add("rst_release_hold", 0, 1, 0, 1, 7'b1000001);

        // 2: clean sclk rise
        add_reset("s2_reset");
        for (int i = 0; i < 4; i++) add("sclk_rise_wait", 0, 1, 1, 0, IDLE);
        add("sclk_rise_edge", 0, 1, 1, 0, 7'b1101000);
        add("sclk_rise_hold", 0, 1, 1, 0, 7'b1001000);

        // 3: 2-cycle glitch rejected, 3-cycle pulse accepted
        add_reset("s3_reset");
        add("glitch2", 0, 1, 1, 0, IDLE);
        add("glitch2", 0, 1, 1, 0, IDLE);
        for (int i = 0; i < 4; i++) add("glitch2_after", 0, 0, 1, 0, IDLE);
        for (int i = 0; i < 3; i++) add("pulse3_hi", 0, 1, 1, 0, IDLE);
        add("pulse3_lo", 0, 0, 1, 0, IDLE);
        add("pulse3_pos", 0, 0, 1, 0, 7'b1101000);
        add("pulse3_high", 0, 0, 1, 0, 7'b1001000);
        add("pulse3_high", 0, 0, 1, 0, 7'b1001000);
        add("pulse3_neg", 0, 0, 1, 0, 7'b0011000);
        add("pulse3_after", 0, 0, 1, 0, IDLE);

        // 4: cs bounce 1,0,1,0,0,0,0
        add_reset("s4_reset");
        add("cs_bounce", 0, 0, 1, 0, IDLE);
        add("cs_bounce", 0, 0, 0, 0, IDLE);
        add("cs_bounce", 0, 0, 1, 0, IDLE);
        for (int i = 0; i < 4; i++) add("cs_bounce_low", 0, 0, 0, 0, IDLE);
        add("cs_bounce_neg", 0, 0, 0, 0, 7'b0000100);
        add("cs_bounce_hold", 0, 0, 0, 0, 7'b0000000);

        // 5: reset while sclk debounce count is 2
        add_reset("s5_reset");
        for (int i = 0; i < 4; i++) add("mid_cnt", 0, 1, 1, 0, IDLE);
        add("mid_cnt_reset", 1, 1, 1, 0, IDLE);
        for (int i = 0; i < 4; i++) add("mid_cnt_restart", 0, 1, 1, 0, IDLE);
        add("mid_cnt_edge", 0, 1, 1, 0, 7'b1101000);
        add("mid_cnt_hold", 0, 1, 1, 0, 7'b1001000);

        // 6: cs fall and sclk rise together
        add_reset("s6_reset");
        for (int i = 0; i < 4; i++) add("simul_wait", 0, 1, 0, 0, IDLE);
        add("simul_edge", 0, 1, 0, 0, 7'b1100100);
        add("simul_hold", 0, 1, 0, 0, 7'b1000000);

        sclk1_pin = 1'b0; cs1_pin = 1'b1; mosi1_pin = 1'b0;
        reset = 1'b1;
        sclk_pin = 1'b0; cs_pin = 1'b1; mosi_pin = 1'b0;
        tick();

        foreach (vecs[i]) begin
            reset    = vecs[i].rst;
            sclk_pin = vecs[i].sclk;
            cs_pin   = vecs[i].cs;
            mosi_pin = vecs[i].mosi;
            tick();
            check(vecs[i].name, obs0, vecs[i].exp);
        end

        // WAIT_TIME=1: one-cycle glitch passes with two edges of delay
        reset = 1'b1;
        tick();
        tick();
        check("w1_reset", obs1, IDLE);
        reset = 1'b0;
        sclk1_pin = 1'b1; cs1_pin = 1'b0;
        tick();
        check("w1_e0", obs1, IDLE);
        sclk1_pin = 1'b0; cs1_pin = 1'b0;
        tick();
        check("w1_e1", obs1, IDLE);
        tick();
        check("w1_rise", obs1, 7'b1100100);
        tick();
        check("w1_fall", obs1, 7'b0010000);
        tick();
        check("w1_idle", obs1, 7'b0000000);
        mosi1_pin = 1'b1;
        tick();
        tick();
        check("w1_mosi_wait", obs1, 7'b0000000);
        tick();
        check("w1_mosi", obs1, 7'b0000001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
